score_streak_engine: RTL and testbench

Parametrised per-player scoring engine for the rhythm game. It takes hit judgements (miss/good/perfect) from the note-judging logic and maintains a score, current streak, best streak and combo multiplier for each of NUM_PLAYERS lanes. It supersedes the single-channel score/streak updater with tiered multipliers, saturation, milestone pulses and a song-restart clear. Outputs feed the HUD/VGA text renderer and the end-of-song results screen.

---
 rtl/score_streak_engine.sv | 129 ++++++++++++
 tb/tb_score_streak_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_streak_engine.sv
// rtl/score_streak_engine.sv - per-player score, streak, best streak and combo multiplier engine
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset, zeroes every channel while low
//   clear        synchronous song-restart, zeroes every channel, beats any judgement
//   judge_valid  bit p = judgement present for player p this cycle
//   judge        bits [2p+1:2p] per player: 00 none, 01 miss, 10 good, 11 perfect
//   score        per-player saturating score, player p at [p*SCORE_W +: SCORE_W]
//   streak       per-player current streak, player p at [p*STREAK_W +: STREAK_W]
//   best_streak  per-player longest streak since reset/clear
//   mult         per-player combo multiplier (1..MAX_MULT), player p at [4p +: 4]
//   milestone    one-cycle pulse when a player's multiplier moves up a tier

module score_streak_engine #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 32,
    parameter int STREAK_W    = 16,
    parameter int GOOD_PTS    = 50,
    parameter int PERFECT_PTS = 100,
    parameter int TIER_LEN    = 10,
    parameter int MAX_MULT    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [NUM_PLAYERS-1:0]          judge_valid,
    input  logic [2*NUM_PLAYERS-1:0]        judge,
    output logic [NUM_PLAYERS*SCORE_W-1:0]  score,
    output logic [NUM_PLAYERS*STREAK_W-1:0] streak,
    output logic [NUM_PLAYERS*STREAK_W-1:0] best_streak,
    output logic [4*NUM_PLAYERS-1:0]        mult,
    output logic [NUM_PLAYERS-1:0]          milestone
);

    // Product must hold the larger base value times the largest legal multiplier (15).
    localparam int BASE_MAX = (PERFECT_PTS > GOOD_PTS) ? PERFECT_PTS : GOOD_PTS;
    localparam int PROD_W_R = $clog2(BASE_MAX * 15 + 1);
    localparam int PROD_W   = (PROD_W_R < 4) ? 4 : PROD_W_R;
    // One bit of headroom over the wider operand so the carry is never lost.
    localparam int SUM_W    = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;

    localparam logic [SUM_W-1:0]    SCORE_MAX = SUM_W'({SCORE_W{1'b1}});
    localparam logic [PROD_W-1:0]   GOOD_B    = PROD_W'(GOOD_PTS);
    localparam logic [PROD_W-1:0]   PERF_B    = PROD_W'(PERFECT_PTS);
    localparam logic [31:0]         TIER_B    = 32'(TIER_LEN);
    localparam logic [31:0]         MMAX_B    = 32'(MAX_MULT);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [SCORE_W-1:0]  score_q;
        logic [STREAK_W-1:0] streak_q;
        logic [STREAK_W-1:0] best_q;
        logic [3:0]          mult_q;
        logic                ms_q;

        logic [1:0]          code;
        logic [PROD_W-1:0]   base_pts;
        logic [PROD_W-1:0]   pts;
        logic [SUM_W-1:0]    sum;
        logic [SCORE_W-1:0]  score_sat;
        logic                streak_full;
        logic [STREAK_W-1:0] streak_inc;
        logic [31:0]         tier_mult;
        logic [3:0]          mult_new;
        logic [STREAK_W-1:0] best_new;

        always_comb begin
            code        = judge[2*p +: 2];
            // Bit 0 separates perfect (11) from good (10).
            base_pts    = code[0] ? PERF_B : GOOD_B;
            // Points use the multiplier in force before this hit lands.
            pts         = base_pts * PROD_W'(mult_q);
            sum         = SUM_W'(score_q) + SUM_W'(pts);
            score_sat   = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

            streak_full = (streak_q == {STREAK_W{1'b1}});
            streak_inc  = streak_q + STREAK_W'(1);

            tier_mult   = 32'(streak_inc) / TIER_B + 32'd1;
            mult_new    = (tier_mult > MMAX_B) ? MMAX_B[3:0] : tier_mult[3:0];

            best_new    = (streak_inc > best_q) ? streak_inc : best_q;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                score_q  <= '0;
                streak_q <= '0;
                best_q   <= '0;
                mult_q   <= 4'd1;
                ms_q     <= 1'b0;
            end else if (clear) begin
                score_q  <= '0;
                streak_q <= '0;
                best_q   <= '0;
                mult_q   <= 4'd1;
                ms_q     <= 1'b0;
            end else begin
                ms_q <= 1'b0;
                if (judge_valid[p]) begin
                    case (code)
                        2'b01: begin
                            streak_q <= '0;
                            mult_q   <= 4'd1;
                        end
                        2'b10, 2'b11: begin
                            // Score keeps accruing even once the streak is pinned.
                            score_q <= score_sat;
                            if (!streak_full) begin
                                streak_q <= streak_inc;
                                mult_q   <= mult_new;
                                best_q   <= best_new;
                                ms_q     <= (mult_new > mult_q);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign score[p*SCORE_W +: SCORE_W]        = score_q;
        assign streak[p*STREAK_W +: STREAK_W]     = streak_q;
        assign best_streak[p*STREAK_W +: STREAK_W] = best_q;
        assign mult[4*p +: 4]                     = mult_q;
        assign milestone[p]                       = ms_q;
    end

endmodule

// File: tb/tb_score_streak_engine.sv
// tb/tb_score_streak_engine.sv - randomized and directed check of score_streak_engine against a reference model

module tb_score_streak_engine;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [1:0] judge_valid;
    logic [3:0] judge;

    // a: defaults, b: STREAK_W=4 TIER_LEN=4, c: SCORE_W=12
    logic [63:0] score_a;  logic [31:0] streak_a; logic [31:0] best_a; logic [7:0] mult_a; logic [1:0] ms_a;
    logic [63:0] score_b;  logic [7:0]  streak_b; logic [7:0]  best_b; logic [7:0] mult_b; logic [1:0] ms_b;
    logic [23:0] score_c;  logic [31:0] streak_c; logic [31:0] best_c; logic [7:0] mult_c; logic [1:0] ms_c;

    score_streak_engine #(.NUM_PLAYERS(2)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .judge_valid(judge_valid), .judge(judge),
        .score(score_a), .streak(streak_a), .best_streak(best_a), .mult(mult_a), .milestone(ms_a)
    );

    score_streak_engine #(.NUM_PLAYERS(2), .STREAK_W(4), .TIER_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .judge_valid(judge_valid), .judge(judge),
        .score(score_b), .streak(streak_b), .best_streak(best_b), .mult(mult_b), .milestone(ms_b)
    );

    score_streak_engine #(.NUM_PLAYERS(2), .SCORE_W(12)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .judge_valid(judge_valid), .judge(judge),
        .score(score_c), .streak(streak_c), .best_streak(best_c), .mult(mult_c), .milestone(ms_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model, one entry per configuration and player.
    int     cfg_sw[3]   = '{32, 32, 12};
    int     cfg_stw[3]  = '{16, 4, 16};
    int     cfg_tier[3] = '{10, 4, 10};
    longint m_score[3][2];
    longint m_streak[3][2];
    longint m_best[3][2];
    longint m_mult[3][2];
    longint m_ms[3][2];

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 2; p++) begin
                m_score[c][p]  = 0;
                m_streak[c][p] = 0;
                m_best[c][p]   = 0;
                m_mult[c][p]   = 1;
                m_ms[c][p]     = 0;
            end
    endtask

    task automatic model_step(input logic clr, input logic [1:0] v, input logic [3:0] j);
        longint smax, stmax, pts, nm;
        logic [1:0] code;
        if (clr) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            smax  = (longint'(1) << cfg_sw[c]) - 1;
            stmax = (longint'(1) << cfg_stw[c]) - 1;
            for (int p = 0; p < 2; p++) begin
                m_ms[c][p] = 0;
                code = j[2*p +: 2];
                if (v[p] && code == 2'b01) begin
                    m_streak[c][p] = 0;
                    m_mult[c][p]   = 1;
                end else if (v[p] && code[1]) begin
                    pts = ((code == 2'b11) ? 100 : 50) * m_mult[c][p];
                    m_score[c][p] = (m_score[c][p] + pts > smax) ? smax : m_score[c][p] + pts;
                    if (m_streak[c][p] < stmax) begin
                        m_streak[c][p]++;
                        nm = 1 + m_streak[c][p] / cfg_tier[c];
                        if (nm > 4) nm = 4;
                        if (nm > m_mult[c][p]) m_ms[c][p] = 1;
                        m_mult[c][p] = nm;
                        if (m_streak[c][p] > m_best[c][p]) m_best[c][p] = m_streak[c][p];
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("a_score%0d", p),  score_a[p*32 +: 32],  m_score[0][p]);
            check($sformatf("a_streak%0d", p), streak_a[p*16 +: 16], m_streak[0][p]);
            check($sformatf("a_best%0d", p),   best_a[p*16 +: 16],   m_best[0][p]);
            check($sformatf("a_mult%0d", p),   mult_a[p*4 +: 4],     m_mult[0][p]);
            check($sformatf("a_ms%0d", p),     ms_a[p],              m_ms[0][p]);
            check($sformatf("b_score%0d", p),  score_b[p*32 +: 32],  m_score[1][p]);
            check($sformatf("b_streak%0d", p), streak_b[p*4 +: 4],   m_streak[1][p]);
            check($sformatf("b_best%0d", p),   best_b[p*4 +: 4],     m_best[1][p]);
            check($sformatf("b_mult%0d", p),   mult_b[p*4 +: 4],     m_mult[1][p]);
            check($sformatf("b_ms%0d", p),     ms_b[p],              m_ms[1][p]);
            check($sformatf("c_score%0d", p),  score_c[p*12 +: 12],  m_score[2][p]);
            check($sformatf("c_streak%0d", p), streak_c[p*16 +: 16], m_streak[2][p]);
            check($sformatf("c_best%0d", p),   best_c[p*16 +: 16],   m_best[2][p]);
            check($sformatf("c_mult%0d", p),   mult_c[p*4 +: 4],     m_mult[2][p]);
            check($sformatf("c_ms%0d", p),     ms_c[p],              m_ms[2][p]);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic drive(input logic clr, input logic [1:0] v, input logic [3:0] j);
        clear       = clr;
        judge_valid = v;
        judge       = j;
        @(posedge clk);
        model_step(clr, v, j);
        @(negedge clk);
        compare_all();
    endtask

    // Pull reset low between edges and look at the outputs before any clock edge arrives.
    task automatic async_reset_pulse();
        clear       = 1'b0;
        judge_valid = 2'b00;
        #2 reset = 1'b0;
        model_reset();
        #1 compare_all();
        check("async_score_a0", score_a[31:0], 0);
        check("async_mult_a0", mult_a[3:0], 1);
        #1 reset = 1'b1;
    endtask

    int ms_cnt;
    logic [1:0] rv;
    logic [3:0] rj;
    int r;

    initial begin
        reset = 1'b0; clear = 1'b0; judge_valid = '0; judge = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_mult_a1", mult_a[7:4], 1);
        reset = 1'b1;

        // Ten perfects on player 0.
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b01, 4'b0011);
        check("t1_score0", score_a[31:0], 1000);
        check("t1_streak0", streak_a[15:0], 10);
        check("t1_mult0", mult_a[3:0], 2);
        check("t1_ms0", ms_a[0], 1);
        check("t1_score1", score_a[63:32], 0);
        drive(1'b0, 2'b00, 4'b0000);
        check("t1_ms0_drop", ms_a[0], 0);

        // Good at x2, then a miss.
        drive(1'b0, 2'b01, 4'b0010);
        check("t2_score0", score_a[31:0], 1100);
        check("t2_streak0", streak_a[15:0], 11);
        drive(1'b0, 2'b01, 4'b0001);
        check("t2_streak_miss", streak_a[15:0], 0);
        check("t2_mult_miss", mult_a[3:0], 1);
        check("t2_score_miss", score_a[31:0], 1100);
        check("t2_best0", best_a[15:0], 11);

        // Simultaneous players, then a valid "none" code.
        drive(1'b0, 2'b11, 4'b0111);
        check("t3_score0", score_a[31:0], 1200);
        check("t3_streak1", streak_a[31:16], 0);
        drive(1'b0, 2'b01, 4'b0000);
        check("t3_none_score0", score_a[31:0], 1200);
        check("t3_none_streak0", streak_a[15:0], 1);

        // Clean start, then 40 perfects to drive score and streak saturation.
        drive(1'b1, 2'b00, 4'b0000);
        ms_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 2'b01, 4'b0011);
            if (ms_b[0]) ms_cnt++;
        end
        check("t4_b_ms_count", ms_cnt, 3);
        check("t4_b_streak0", streak_b[3:0], 15);
        check("t4_b_best0", best_b[3:0], 15);
        check("t4_b_mult0", mult_b[3:0], 4);
        check("t4_c_score0", score_c[11:0], 4095);
        check("t4_c_streak0", streak_c[15:0], 40);
        check("t4_a_score0", score_a[31:0], 10000);

        // Clear beats simultaneous perfects on both players.
        drive(1'b1, 2'b11, 4'b1111);
        check("t5_score0", score_a[31:0], 0);
        check("t5_mult1", mult_a[7:4], 1);
        check("t5_best0", best_a[15:0], 0);

        // Async reset mid-stream.
        for (int i = 0; i < 5; i++) drive(1'b0, 2'b11, 4'b1011);
        async_reset_pulse();

        // Randomized traffic, hits weighted so the streak limits get exercised.
        for (int i = 0; i < 3000; i++) begin
            rv = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                r = $urandom_range(0, 11);
                rj[2*p +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            end
            drive(($urandom_range(0, 199) == 0), rv, rj);
            if (i % 700 == 699) async_reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
